spram_fifo_ctrl: RTL and testbench

//   FIFO controller that drives one single-port synchronous RAM (spram, 1-cycle

---
 rtl/spram_fifo_ctrl.sv | 86 ++++++++
 tb/tb_spram_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller for a single-port synchronous RAM with a one-word prefetched output register.
// Reads take priority on the shared port; the output register makes capacity 2**ADDR + 1 words.
module spram_fifo_ctrl #(
  parameter int DATA = 16,
  parameter int ADDR = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DATA-1:0] wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DATA-1:0] rd_data,
  output logic            ram_we,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_din,
  input  logic [DATA-1:0] ram_dout,
  output logic [ADDR:0]   count,
  output logic            full,
  output logic            empty
);

  localparam int CW = ADDR + 1;
  localparam logic [ADDR:0] DEPTH = CW'(1 << ADDR);

  logic [ADDR-1:0] wr_ptr;
  logic [ADDR-1:0] rd_ptr;
  logic [ADDR:0]   mcount;
  logic            rd_pend;
  logic            rd_issue;
  logic            wr_acc;

  function automatic logic [ADDR:0] total_words(input logic [ADDR:0] m, input logic p,
                                                input logic v);
    return m + CW'(p) + CW'(v);
  endfunction

  // Port arbitration: at most one RAM access per cycle, reads first.
  // rd_pend blocks back-to-back reads so writes always get every other cycle.
  always_comb begin
    rd_issue = (mcount != '0) && !rd_pend && (!rd_valid || rd_ready);
    wr_ready = !rd_issue && (mcount != DEPTH);
    wr_acc   = wr_valid && wr_ready;
    ram_we   = wr_acc;
    ram_addr = wr_acc ? wr_ptr : rd_ptr;
    ram_din  = wr_data;
    full     = (mcount == DEPTH);
    count    = total_words(mcount, rd_pend, rd_valid);
    empty    = (count == '0);
  end

  // Stage 0: pointer and RAM occupancy bookkeeping on the issuing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mcount  <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) begin
        rd_ptr <= rd_ptr + ADDR'(1);
        mcount <= mcount - CW'(1);
      end else if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR'(1);
        mcount <= mcount + CW'(1);
      end
    end
  end

  // Stage 1: RAM read data lands in the output register one cycle after issue.
  // The slot is guaranteed free here because issue required it to be empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_pend) begin
      rd_valid <= 1'b1;
      rd_data  <= ram_dout;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Directed bench for spram_fifo_ctrl with a behavioural read-first single-port RAM attached.
module tb_spram_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        ram_we;
  logic [4:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [5:0]  count;
  logic        full;
  logic        empty;

  spram_fifo_ctrl #(.DATA(16), .ADDR(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .count(count), .full(full), .empty(empty)
  );

  // Read-first single-port RAM, one registered access per cycle.
  logic [15:0] mem [0:31];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nchk = 0;
  int npass = 0;
  int nfail = 0;
  int cnt = 0;
  int ntake = 0;
  logic [4:0] wptr_m = '0;
  logic [15:0] q[$];
  logic last_acc;
  logic last_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    cnt = 0;
    wptr_m = '0;
  endtask

  // One clock cycle: drive inputs, sample handshakes before the edge, update model after it.
  task automatic tick(input logic wv, input logic [15:0] wd, input logic rr);
    logic acc, take, we_s;
    logic [4:0] addr_s;
    logic [15:0] td, exp;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
    acc    = wr_valid && wr_ready;
    take   = rd_valid && rd_ready;
    we_s   = ram_we;
    addr_s = ram_addr;
    td     = rd_data;
    check("we_vs_handshake", 32'(we_s), 32'(acc));
    if (acc) begin
      check("write_addr", 32'(addr_s), 32'(wptr_m));
      wptr_m = wptr_m + 5'd1;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      q.push_back(wd);
      cnt++;
    end
    if (take) begin
      ntake++;
      cnt--;
      if (q.size() > 0) begin
        exp = q.pop_front();
        check("read_order", 32'(td), 32'(exp));
      end else begin
        nchk++;
        nfail++;
        $error("FAIL read_underflow: observed rd_data 0x%0h expected no word", td);
      end
    end
    check("count_model", 32'(count), 32'(cnt));
    check("empty_model", 32'(empty), 32'(cnt == 0));
    last_stall = wv && !acc;
    last_acc = acc;
  endtask

  task automatic push(input logic [15:0] w, input logic rr, output int stalls);
    stalls = 0;
    tick(1'b1, w, rr);
    while (!last_acc && stalls < 40) begin
      stalls++;
      tick(1'b1, w, rr);
    end
    if (!last_acc) begin
      nchk++;
      nfail++;
      $error("FAIL push_timeout: observed no accept for 0x%0h expected accept", w);
    end
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int st;
    int nxt;
    int start;
    logic prev_stall;
    logic [15:0] seq;

    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    rst_n    = 1'b0;
    last_acc = 1'b0;
    last_stall = 1'b0;

    // 1. Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_ram_we", 32'(ram_we), 0);

    // 2. Three writes, output held with rd_ready low
    push(16'h0001, 1'b0, st);
    check("w1_stalls", 32'(st), 0);
    push(16'h0002, 1'b0, st);
    check("w2_stalls", 32'(st), 1);
    push(16'h0003, 1'b0, st);
    check("w3_stalls", 32'(st), 0);
    check("t2_rd_valid", 32'(rd_valid), 1);
    check("t2_rd_data", 32'(rd_data), 32'h0001);
    check("t2_count", 32'(count), 3);
    repeat (3) tick(1'b0, 16'h0, 1'b0);
    check("t2_hold_data", 32'(rd_data), 32'h0001);
    check("t2_hold_valid", 32'(rd_valid), 1);
    repeat (10) tick(1'b0, 16'h0, 1'b1);
    check("t2_drained", 32'(count), 0);

    // 3. Fill to capacity
    do_reset();
    for (int i = 0; i < 33; i++) push(16'(i), 1'b0, st);
    wr_valid = 1'b1;
    wr_data  = 16'd33;
    #1;
    check("fill_full", 32'(full), 1);
    check("fill_wr_ready", 32'(wr_ready), 0);
    check("fill_count", 32'(count), 33);
    repeat (3) begin
      tick(1'b1, 16'd33, 1'b0);
      check("fill_34th_rejected", 32'(last_acc), 0);
    end
    repeat (80) tick(1'b0, 16'h0, 1'b1);
    check("fill_drained", 32'(cnt), 0);
    check("fill_taken", 32'(ntake), 36);

    // 4. Streaming with both sides always willing
    do_reset();
    nxt = 0;
    start = ntake;
    prev_stall = 1'b0;
    for (int i = 0; i < 1500 && (ntake - start) < 200; i++) begin
      tick(nxt < 200, 16'(nxt), 1'b1);
      if (last_acc) nxt++;
      check("stream_no_double_stall", 32'(prev_stall && last_stall), 0);
      prev_stall = last_stall;
    end
    check("stream_taken", 32'(ntake - start), 200);
    check("stream_queue_empty", 32'(q.size()), 0);

    // 5. Random traffic against the scoreboard
    do_reset();
    seq = 16'h1000;
    for (int i = 0; i < 2000; i++) begin
      tick(1'($urandom_range(0, 1)), seq, 1'($urandom_range(0, 1)));
      if (last_acc) seq = seq + 16'd1;
    end
    for (int i = 0; i < 200 && cnt != 0; i++) tick(1'b0, 16'h0, 1'b1);
    check("rand_drained", 32'(count), 0);

    // 6. Asynchronous reset with a read in flight
    do_reset();
    for (int i = 0; i < 6; i++) push(16'(16'h0010 + i), 1'b0, st);
    tick(1'b0, 16'h0, 1'b1);
    check("t6_count_pre", 32'(count), 5);
    check("t6_rd_valid_pre", 32'(rd_valid), 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_rd_valid", 32'(rd_valid), 0);
    check("t6_rst_empty", 32'(empty), 1);
    check("t6_rst_rd_data", 32'(rd_data), 0);
    check("t6_rst_full", 32'(full), 0);
    model_clear();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(16'hBEEF, 1'b0, st);
    for (int i = 0; i < 10 && !rd_valid; i++) tick(1'b0, 16'h0, 1'b0);
    check("t6_first_valid", 32'(rd_valid), 1);
    check("t6_first_data", 32'(rd_data), 32'hBEEF);
    check("t6_count_post", 32'(count), 1);
    tick(1'b0, 16'h0, 1'b1);
    check("t6_final_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
